// File: rtl/cam_window_sched.sv
// cam_window_sched: per-pixel window scheduler for the four-camera VGA compositor.
// Chooses which camera buffer owns each VGA pixel, using a fixed priority.
// Drives local read addresses to every buffer and returns the selected RGB565 word.
// Owns the user window offsets: debounced key stepping, saturation, and a frame-synchronous update.
// Optional feature macro: CAM_WIN_BORDER_EN paints a one-pixel white frame on each owned window.
module cam_window_sched #(
   parameter int WIN_W    = 174,
   parameter int WIN_H    = 144,
   parameter int BASE_X   = 40,
   parameter int OFFX_MAX = 200,
   parameter int OFFY_MAX = 96,
   parameter int DEBOUNCE = 250000,
   parameter int RD_LAT   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        vsync_n,
   input  logic        key_x_n,
   input  logic        key_y_n,
   input  logic [15:0] cam_value0,
   input  logic [15:0] cam_value1,
   input  logic [15:0] cam_value2,
   input  logic [15:0] cam_value3,
   output logic [9:0]  x_addr0,
   output logic [9:0]  x_addr1,
   output logic [9:0]  x_addr2,
   output logic [9:0]  x_addr3,
   output logic [9:0]  y_addr0,
   output logic [9:0]  y_addr1,
   output logic [9:0]  y_addr2,
   output logic [9:0]  y_addr3,
   output logic [15:0] rgb_out,
   output logic [2:0]  cam_sel,
   output logic [9:0]  offset_x,
   output logic [9:0]  offset_y
);

   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam logic [2:0] SEL_BG = 3'd4;

   // Fixed window bounds (cam0/cam2 columns, cam1/cam3 rows) centred on the 640x480 screen.
   localparam logic [9:0] MID_L = 10'(320 - WIN_W / 2);
   localparam logic [9:0] MID_R = 10'(320 + WIN_W / 2);
   localparam logic [9:0] MID_T = 10'(240 - WIN_H / 2);
   localparam logic [9:0] MID_B = 10'(240 + WIN_H / 2);

   logic [1:0]    key_meta, key_sync, key_stable, step;
   logic [CW-1:0] db_cnt [2];
   logic [9:0]    shadow_x, shadow_y, active_x, active_y;
   logic          vs_q1, vs_q2, vs_fall;
   logic [9:0]    win_l [4];
   logic [9:0]    win_r [4];
   logic [9:0]    win_t [4];
   logic [9:0]    win_b [4];
   logic [9:0]    lx [4];
   logic [9:0]    ly [4];
   logic [3:0]    in_win;
   logic [2:0]    sel_next, sel1, sel_d;
   logic [2:0]    sel_pipe [RD_LAT];
`ifdef CAM_WIN_BORDER_EN
   logic          border_next, border1, border_d;
   logic          border_pipe [RD_LAT];
`endif

   // Two-flop synchroniser on both raw keys; released level is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         key_meta <= 2'b11;
         key_sync <= 2'b11;
      end else begin
         key_meta <= {key_y_n, key_x_n};
         key_sync <= key_meta;
      end
   end

   // Debounce: accept a new level after DEBOUNCE consecutive differing samples, pulse once on press.
   always_ff @(posedge clk) begin
      if (reset) begin
         key_stable <= 2'b11;
         step       <= 2'b00;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         step <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            if (key_sync[i] == key_stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CW'(DEBOUNCE - 1)) begin
               key_stable[i] <= key_sync[i];
               db_cnt[i]     <= '0;
               step[i]       <= ~key_sync[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Shadow step counters, saturating; X and Y steps in the same cycle both apply.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_x <= '0;
         shadow_y <= '0;
      end else begin
         if (step[0] && shadow_x != 10'(OFFX_MAX)) shadow_x <= shadow_x + 10'd1;
         if (step[1] && shadow_y != 10'(OFFY_MAX)) shadow_y <= shadow_y + 10'd1;
      end
   end

   // Register vsync_n twice so its falling edge is detected cleanly.
   always_ff @(posedge clk) begin
      if (reset) begin
         vs_q1 <= 1'b1;
         vs_q2 <= 1'b1;
      end else begin
         vs_q1 <= vsync_n;
         vs_q2 <= vs_q1;
      end
   end

   assign vs_fall = vs_q2 & ~vs_q1;

   // Active offsets only change at frame start, so a frame is never drawn with mixed offsets.
   always_ff @(posedge clk) begin
      if (reset) begin
         active_x <= '0;
         active_y <= '0;
      end else if (vs_fall) begin
         active_x <= shadow_x;
         active_y <= shadow_y;
      end
   end

   assign offset_x = 10'(BASE_X) + active_x;
   assign offset_y = active_y;

   // Window bounds, zero-based local coordinates and fixed-priority owner for the current pixel.
   always_comb begin
      win_l[0] = MID_L;                          win_r[0] = MID_R;
      win_t[0] = offset_y;                       win_b[0] = 10'(WIN_H) + offset_y;
      win_l[1] = 10'(640 - WIN_W) - offset_x;    win_r[1] = 10'd640 - offset_x;
      win_t[1] = MID_T;                          win_b[1] = MID_B;
      win_l[2] = MID_L;                          win_r[2] = MID_R;
      win_t[2] = 10'(480 - WIN_H) - offset_y;    win_b[2] = 10'd480 - offset_y;
      win_l[3] = offset_x;                       win_r[3] = 10'(WIN_W) + offset_x;
      win_t[3] = MID_T;                          win_b[3] = MID_B;
      for (int k = 0; k < 4; k++) begin
         lx[k]     = pixel_x - (win_l[k] + 10'd1);
         ly[k]     = pixel_y - (win_t[k] + 10'd1);
         in_win[k] = (pixel_x > win_l[k]) && (pixel_x <= win_r[k]) &&
                     (pixel_y > win_t[k]) && (pixel_y <= win_b[k]);
      end
      if (in_win[0])      sel_next = 3'd0;
      else if (in_win[1]) sel_next = 3'd1;
      else if (in_win[2]) sel_next = 3'd2;
      else if (in_win[3]) sel_next = 3'd3;
      else                sel_next = SEL_BG;
   end

`ifdef CAM_WIN_BORDER_EN
   // Border flag for the owning window: first or last local row or column.
   always_comb begin
      border_next = 1'b0;
      if (sel_next != SEL_BG) begin
         border_next = (lx[sel_next[1:0]] == 10'd0) || (lx[sel_next[1:0]] == 10'(WIN_W - 1)) ||
                       (ly[sel_next[1:0]] == 10'd0) || (ly[sel_next[1:0]] == 10'(WIN_H - 1));
      end
   end
`endif

   // Stage n+1: register all eight buffer addresses and the owner code.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_addr0 <= '0; x_addr1 <= '0; x_addr2 <= '0; x_addr3 <= '0;
         y_addr0 <= '0; y_addr1 <= '0; y_addr2 <= '0; y_addr3 <= '0;
         sel1    <= SEL_BG;
`ifdef CAM_WIN_BORDER_EN
         border1 <= 1'b0;
`endif
      end else begin
         x_addr0 <= lx[0]; x_addr1 <= lx[1]; x_addr2 <= lx[2]; x_addr3 <= lx[3];
         y_addr0 <= ly[0]; y_addr1 <= ly[1]; y_addr2 <= ly[2]; y_addr3 <= ly[3];
         sel1    <= sel_next;
`ifdef CAM_WIN_BORDER_EN
         border1 <= border_next;
`endif
      end
   end

   // Delay the owner code by the buffer read latency so it lines up with cam_valueK.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RD_LAT; i++) sel_pipe[i] <= SEL_BG;
`ifdef CAM_WIN_BORDER_EN
         for (int i = 0; i < RD_LAT; i++) border_pipe[i] <= 1'b0;
`endif
      end else begin
         sel_pipe[0] <= sel1;
         for (int i = 1; i < RD_LAT; i++) sel_pipe[i] <= sel_pipe[i-1];
`ifdef CAM_WIN_BORDER_EN
         border_pipe[0] <= border1;
         for (int i = 1; i < RD_LAT; i++) border_pipe[i] <= border_pipe[i-1];
`endif
      end
   end

   assign sel_d = sel_pipe[RD_LAT-1];
`ifdef CAM_WIN_BORDER_EN
   assign border_d = border_pipe[RD_LAT-1];
`endif

   // Output stage: select the owning buffer's word, black for background.
   always_ff @(posedge clk) begin
      if (reset) begin
         rgb_out <= 16'h0000;
         cam_sel <= SEL_BG;
      end else begin
         cam_sel <= sel_d;
         case (sel_d)
            3'd0:    rgb_out <= cam_value0;
            3'd1:    rgb_out <= cam_value1;
            3'd2:    rgb_out <= cam_value2;
            3'd3:    rgb_out <= cam_value3;
            default: rgb_out <= 16'h0000;
         endcase
`ifdef CAM_WIN_BORDER_EN
         if (border_d && sel_d != SEL_BG) rgb_out <= 16'hFFFF;
`endif
      end
   end

endmodule

// File: tb/tb_cam_window_sched.sv
// tb_cam_window_sched: directed self-checking bench for cam_window_sched.
// The camera buffers are modelled as 1-cycle RAMs returning {cam, x[6:0], y[6:0]}.
// Debounce is shortened so key presses take tens of cycles; CAM_WIN_BORDER_EN selects border checks.
module tb_cam_window_sched;

   localparam int DB = 16;
   localparam int PRESS = DB + 5;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  pixel_x, pixel_y;
   logic        vsync_n, key_x_n, key_y_n;
   logic [15:0] cam_value0, cam_value1, cam_value2, cam_value3;
   logic [9:0]  x_addr0, x_addr1, x_addr2, x_addr3;
   logic [9:0]  y_addr0, y_addr1, y_addr2, y_addr3;
   logic [15:0] rgb_out;
   logic [2:0]  cam_sel;
   logic [9:0]  offset_x, offset_y;

   int errors = 0;
   int checks = 0;

   cam_window_sched #(.DEBOUNCE(DB), .RD_LAT(1)) dut (
      .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y), .vsync_n(vsync_n),
      .key_x_n(key_x_n), .key_y_n(key_y_n),
      .cam_value0(cam_value0), .cam_value1(cam_value1), .cam_value2(cam_value2), .cam_value3(cam_value3),
      .x_addr0(x_addr0), .x_addr1(x_addr1), .x_addr2(x_addr2), .x_addr3(x_addr3),
      .y_addr0(y_addr0), .y_addr1(y_addr1), .y_addr2(y_addr2), .y_addr3(y_addr3),
      .rgb_out(rgb_out), .cam_sel(cam_sel), .offset_x(offset_x), .offset_y(offset_y)
   );

   // Free-running pixel clock.
   always #5 clk = ~clk;

   // Buffer data word tagged with the camera number and the local coordinate it was read from.
   function automatic logic [15:0] bufWord(input logic [1:0] k, input logic [9:0] x, input logic [9:0] y);
      return {k, x[6:0], y[6:0]};
   endfunction

   // Camera buffer model with one cycle of read latency.
   always @(posedge clk) begin
      cam_value0 <= bufWord(2'd0, x_addr0, y_addr0);
      cam_value1 <= bufWord(2'd1, x_addr1, y_addr1);
      cam_value2 <= bufWord(2'd2, x_addr2, y_addr2);
      cam_value3 <= bufWord(2'd3, x_addr3, y_addr3);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int x, input int y);
      pixel_x = 10'(x);
      pixel_y = 10'(y);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic pressKeys(input logic px, input logic py, input int hold);
      key_x_n = ~px;
      key_y_n = ~py;
      tick(hold);
      key_x_n = 1'b1;
      key_y_n = 1'b1;
      tick(PRESS);
   endtask

   task automatic frameStart();
      vsync_n = 1'b0;
      tick(4);
      vsync_n = 1'b1;
      tick(4);
   endtask

   initial begin
      reset = 1'b1; vsync_n = 1'b1; key_x_n = 1'b1; key_y_n = 1'b1;
      applyStimulus(0, 0);
      tick(3);
      $display("[TB] reset values");
      checkOutput("rst_cam_sel", 32'(cam_sel), 4);
      checkOutput("rst_rgb", 32'(rgb_out), 0);
      checkOutput("rst_x_addr0", 32'(x_addr0), 0);
      checkOutput("rst_y_addr3", 32'(y_addr3), 0);
      checkOutput("rst_offset_x", 32'(offset_x), 40);
      checkOutput("rst_offset_y", 32'(offset_y), 0);
      reset = 1'b0;
      tick(4);

      $display("[TB] cam0 centre pixel and latency");
      applyStimulus(320, 10);
      tick(2);
      checkOutput("lat_early_sel", 32'(cam_sel), 4);
      tick(1);
      checkOutput("c0_sel", 32'(cam_sel), 0);
      checkOutput("c0_rgb", 32'(rgb_out), 32'(bufWord(2'd0, 10'd86, 10'd9)));
      checkOutput("c0_x_addr0", 32'(x_addr0), 86);
      checkOutput("c0_y_addr0", 32'(y_addr0), 9);
      checkOutput("c0_x_addr1_wrap", 32'(x_addr1), 917);

      applyStimulus(600, 200);
      tick(3);
      checkOutput("c1_sel", 32'(cam_sel), 1);
      checkOutput("c1_x_addr1", 32'(x_addr1), 173);
      checkOutput("c1_y_addr1", 32'(y_addr1), 31);
      checkOutput("c1_rgb", 32'(rgb_out), 32'(bufWord(2'd1, 10'd173, 10'd31)));

      applyStimulus(0, 0);
      tick(3);
      checkOutput("bg_sel", 32'(cam_sel), 4);
      checkOutput("bg_rgb", 32'(rgb_out), 0);

      $display("[TB] window edges");
      applyStimulus(233, 10);
      tick(3);
      checkOutput("edge_left_excl", 32'(cam_sel), 4);
      applyStimulus(407, 144);
      tick(3);
      checkOutput("edge_br_incl", 32'(cam_sel), 0);
      checkOutput("edge_br_x", 32'(x_addr0), 173);
      checkOutput("edge_br_y", 32'(y_addr0), 143);
      applyStimulus(407, 145);
      tick(3);
      checkOutput("edge_bottom_excl", 32'(cam_sel), 4);

      $display("[TB] key stepping");
      pressKeys(1'b1, 1'b0, PRESS);
      checkOutput("press_no_vsync", 32'(offset_x), 40);
      frameStart();
      checkOutput("press_after_vsync", 32'(offset_x), 41);
      pressKeys(1'b1, 1'b0, DB - 4);
      frameStart();
      checkOutput("glitch_ignored", 32'(offset_x), 41);
      pressKeys(1'b1, 1'b1, PRESS);
      checkOutput("midframe_x_hold", 32'(offset_x), 41);
      checkOutput("midframe_y_hold", 32'(offset_y), 0);
      frameStart();
      checkOutput("both_x", 32'(offset_x), 42);
      checkOutput("both_y", 32'(offset_y), 1);
      for (int i = 0; i < 250; i++) pressKeys(1'b1, 1'b1, PRESS);
      frameStart();
      checkOutput("sat_x", 32'(offset_x), 240);
      checkOutput("sat_y", 32'(offset_y), 96);
      pressKeys(1'b1, 1'b1, PRESS);
      frameStart();
      checkOutput("sat_x_hold", 32'(offset_x), 240);
      checkOutput("sat_y_hold", 32'(offset_y), 96);

      $display("[TB] overlap and priority at offset_x=240 offset_y=96");
      applyStimulus(300, 200);
      tick(3);
      checkOutput("ovl_sel", 32'(cam_sel), 0);
      checkOutput("ovl_rgb", 32'(rgb_out), 32'(bufWord(2'd0, 10'd66, 10'd103)));
      checkOutput("ovl_x_addr3", 32'(x_addr3), 59);
      checkOutput("ovl_x_addr1", 32'(x_addr1), 73);
      applyStimulus(300, 300);
      tick(3);
      checkOutput("ovl13_sel", 32'(cam_sel), 1);
      checkOutput("ovl13_y_addr1", 32'(y_addr1), 131);
      applyStimulus(300, 350);
      tick(3);
      checkOutput("c2_sel", 32'(cam_sel), 2);
      checkOutput("c2_rgb", 32'(rgb_out), 32'(bufWord(2'd2, 10'd66, 10'd109)));
      applyStimulus(410, 200);
      tick(3);
      checkOutput("c3_sel", 32'(cam_sel), 3);
      checkOutput("c3_rgb", 32'(rgb_out), 32'(bufWord(2'd3, 10'd169, 10'd31)));

      $display("[TB] reset mid-frame");
      reset = 1'b1;
      applyStimulus(0, 0);
      tick(1);
      checkOutput("mrst_offset_x", 32'(offset_x), 40);
      checkOutput("mrst_offset_y", 32'(offset_y), 0);
      checkOutput("mrst_sel", 32'(cam_sel), 4);
      reset = 1'b0;
      tick(3);
      checkOutput("mrst_flush_sel", 32'(cam_sel), 4);
      checkOutput("mrst_flush_rgb", 32'(rgb_out), 0);

      $display("[TB] window border");
      applyStimulus(234, 1);
      tick(3);
      checkOutput("brd_corner_sel", 32'(cam_sel), 0);
`ifdef CAM_WIN_BORDER_EN
      checkOutput("brd_corner_rgb", 32'(rgb_out), 32'h0000FFFF);
`else
      checkOutput("brd_corner_rgb", 32'(rgb_out), 32'(bufWord(2'd0, 10'd0, 10'd0)));
`endif
      applyStimulus(235, 2);
      tick(3);
      checkOutput("brd_inner_rgb", 32'(rgb_out), 32'(bufWord(2'd0, 10'd1, 10'd1)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
